// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the CPU FSM and an I/O requester, one transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating tie-break; otherwise the CPU always wins a tie.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StRdata} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;  // 0 = CPU, 1 = IO
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pick_io;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_winner_q, last_winner_d;  // 0 = CPU, 1 = IO

  assign pick_io = io_req & (~cpu_req | ~last_winner_q);
`else
  assign pick_io = io_req & ~cpu_req;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_winner_d = last_winner_q;
`endif
    cpu_gnt    = 1'b0;
    io_gnt     = 1'b0;
    cpu_rvalid = 1'b0;
    io_rvalid  = 1'b0;
    cpu_rdata  = '0;
    io_rdata   = '0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;

    unique case (state_q)
      StIdle: begin
        // Grant is combinational, so it must be masked while reset is held.
        if (reset && (cpu_req || io_req)) begin
          owner_d = pick_io;
          state_d = StAccess;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_winner_d = pick_io;
`endif
          if (pick_io) begin
            io_gnt  = 1'b1;
            we_d    = io_we;
            addr_d  = io_addr;
            wdata_d = io_wdata;
          end else begin
            cpu_gnt = 1'b1;
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      StAccess: begin
        ram_en    = 1'b1;
        ram_we    = we_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        state_d   = we_q ? StIdle : StRdata;
      end
      StRdata: begin
        if (owner_q) begin
          io_rvalid = 1'b1;
          io_rdata  = ram_rdata;
        end else begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = ram_rdata;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Reset to IO so that the CPU wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_winner_q <= 1'b1;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized CPU/IO requesters and a RAM model; a transaction-level reference feeds a scoreboard.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          io_req = 1'b0, io_we = 1'b0;
  logic [AW-1:0] io_addr = '0;
  logic [DW-1:0] io_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, io_gnt, io_rvalid;
  logic [DW-1:0] cpu_rdata, io_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .io_req     (io_req),
    .io_we      (io_we),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_gnt     (io_gnt),
    .io_rvalid  (io_rvalid),
    .io_rdata   (io_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: 1-cycle synchronous read, low 8 address bits decoded.
  logic [DW-1:0] ram_arr [0:255];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_arr[ram_addr[7:0]] <= ram_wdata;
      else        ram_rdata <= ram_arr[ram_addr[7:0]];
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endfunction

  typedef struct { int cyc; logic who; } gnt_t;
  typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } acc_t;
  typedef struct { int cyc; logic who; logic [DW-1:0] data; } rd_t;

  gnt_t gq[$];
  acc_t aq[$];
  rd_t  rq[$];

  // Reference: a granted transaction occupies the port for 2 (write) or 3 (read) cycles.
  logic [DW-1:0] ref_mem [0:255];
  int   free_at = 0;
  logic last_io = 1'b1;

  always @(negedge clk) begin
    logic win_io;
    logic          t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    if (!reset) begin
      gq.delete(); aq.delete(); rq.delete();
      free_at = 0;
      last_io = 1'b1;
    end else if (cyc >= free_at && (cpu_req || io_req)) begin
      if (cpu_req && io_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win_io = !last_io;
`else
        win_io = 1'b0;
`endif
      end else begin
        win_io = io_req;
      end
      last_io = win_io;
      t_we    = win_io ? io_we : cpu_we;
      t_addr  = win_io ? io_addr : cpu_addr;
      t_wdata = win_io ? io_wdata : cpu_wdata;
      gq.push_back('{cyc, win_io});
      aq.push_back('{cyc + 1, t_we, t_addr, t_wdata});
      if (t_we) begin
        ref_mem[t_addr[7:0]] = t_wdata;
        free_at = cyc + 2;
      end else begin
        rq.push_back('{cyc + 2, win_io, ref_mem[t_addr[7:0]]});
        free_at = cyc + 3;
      end
    end
  end

  // Monitor: every cycle, compare each output group against its queue (or against idle zeros).
  always @(negedge clk) begin
    gnt_t g;
    acc_t a;
    rd_t  r;
    #1;
    if (gq.size() > 0 && gq[0].cyc == cyc) begin
      g = gq.pop_front();
      check("gnt", {62'd0, cpu_gnt, io_gnt}, {62'd0, !g.who, g.who});
    end else begin
      check("gnt_idle", {62'd0, cpu_gnt, io_gnt}, 64'd0);
    end
    if (aq.size() > 0 && aq[0].cyc == cyc) begin
      a = aq.pop_front();
      check("ram_access", {30'd0, ram_en, ram_we, ram_addr, ram_wdata},
            {30'd0, 1'b1, a.we, a.addr, a.wdata});
    end else begin
      check("ram_idle", {30'd0, ram_en, ram_we, ram_addr, ram_wdata}, 64'd0);
    end
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      r = rq.pop_front();
      check("rdata", {30'd0, cpu_rvalid, io_rvalid, cpu_rdata, io_rdata},
            {30'd0, !r.who, r.who, r.who ? 16'h0 : r.data, r.who ? r.data : 16'h0});
    end else begin
      check("rdata_idle", {30'd0, cpu_rvalid, io_rvalid, cpu_rdata, io_rdata}, 64'd0);
    end
  end

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom);
    if ($urandom_range(0, 3) != 0) a = {11'd0, a[4:0]};
    return a;
  endfunction

  // Requester behaviour: hold until granted, then scramble inputs; rarely abandon a request.
  task automatic next_req(input logic took, inout logic req, inout logic we,
                          inout logic [AW-1:0] addr, inout logic [DW-1:0] wdata);
    if (took) begin
      req   = 1'b0;
      we    = 1'($urandom);
      addr  = AW'($urandom);
      wdata = DW'($urandom);
    end else if (req) begin
      if ($urandom_range(0, 15) == 0) req = 1'b0;
      return;
    end
    if (!req && $urandom_range(0, 3) != 0) begin
      req   = 1'b1;
      we    = ($urandom_range(0, 2) == 0);
      addr  = rand_addr();
      wdata = DW'($urandom);
    end
  endtask

  task automatic wait_gnt(input logic is_io, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      seen = is_io ? io_gnt : cpu_gnt;
    end
    check(name, {63'd0, seen}, 64'd1);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    cpu_req = 1'b0;
    io_req  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    logic cg, ig;
    int   n_cpu, n_io;
    for (int i = 0; i < 256; i++) begin
      ram_arr[i] = '0;
      ref_mem[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, ram_en, ram_we,
                            ram_addr, ram_wdata, cpu_rdata, io_rdata}, 64'd0);
    #2 reset = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      cg = cpu_gnt;
      ig = io_gnt;
      @(posedge clk); #1;
      next_req(cg, cpu_req, cpu_we, cpu_addr, cpu_wdata);
      next_req(ig, io_req, io_we, io_addr, io_wdata);
    end
    drain();

    // CPU write 0x0010 <- 0xBEEF, address changed right after grant.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    wait_gnt(1'b0, "cpu_write_gnt");
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    drain();

    // CPU read 0x0010.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    wait_gnt(1'b0, "cpu_read_gnt");
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_addr = 16'h0020;
    @(posedge clk); #1;
    check("cpu_read_beef", {46'd0, cpu_rvalid, io_rvalid, cpu_rdata}, {46'd0, 2'b10, 16'hBEEF});
    drain();

    // Both requesters reading continuously: four grants in twelve cycles.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0003;
    io_req  = 1'b1; io_we  = 1'b0; io_addr  = 16'h0004;
    n_cpu = 0;
    n_io  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      n_cpu += int'(cpu_gnt);
      n_io  += int'(io_gnt);
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("tie_cpu_count", 64'(n_cpu), 64'd2);
    check("tie_io_count", 64'(n_io), 64'd2);
`else
    check("tie_cpu_count", 64'(n_cpu), 64'd4);
    check("tie_io_count", 64'(n_io), 64'd0);
`endif
    drain();

    // IO read of 0x0010 interrupted by reset during its data cycle.
    io_req = 1'b1; io_we = 1'b0; io_addr = 16'h0010;
    wait_gnt(1'b1, "io_read_gnt");
    @(posedge clk); #1;
    io_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    @(posedge clk); #3;
    check("io_rdata_before_reset", {46'd0, cpu_rvalid, io_rvalid, io_rdata},
          {46'd0, 2'b01, 16'hBEEF});
    reset = 1'b0;
    #1;
    check("reset_mid_rdata", {cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, ram_en, ram_we,
                              ram_addr, ram_wdata, cpu_rdata, io_rdata}, 64'd0);
    io_req = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    // Tie on the first active cycle goes to the CPU in either arbitration mode.
    @(negedge clk); #1;
    check("gnt_after_release", {62'd0, cpu_gnt, io_gnt}, 64'd2);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    wait_gnt(1'b1, "io_gnt_after_cpu");
    drain();

    repeat (4) @(posedge clk);
    check("queues_drained", 64'(gq.size() + aq.size() + rq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port instruction/data block RAM. It shares the RAM port between the CPU control FSM (instruction fetch, LOAD, STOR) and a secondary I/O requester (memory-mapped peripheral / debug loader). It accepts one transaction at a time, latches it, drives the RAM for one cycle, and returns read data with a valid strobe once the RAM's 1-cycle synchronous read latency has elapsed.

## Interface
- ADDR_W, 16, RAM address width
- DATA_W, 16, RAM data width

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU transaction request; held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DATA_W  read data; 0 when cpu_rvalid=0
- io_req, io_we, io_addr, io_wdata  in  1/1/ADDR_W/DATA_W  I/O requester, same rules as CPU
- io_gnt, io_rvalid  out  1  as CPU
- io_rdata  out  DATA_W  as CPU
- ram_en  out  1  RAM port enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0

## Operation
- States: IDLE, ACCESS, RDATA. Internal regs: owner (0=CPU,1=IO), we_q, addr_q, wdata_q, last_winner.
- IDLE: if any req, pick winner, pulse that requester's gnt (combinational, same cycle), latch we/addr/wdata into *_q, set owner, update last_winner; next ACCESS. No req: stay IDLE.
- ACCESS: ram_en=1, ram_we=we_q, ram_addr=addr_q, ram_wdata=wdata_q. Write -> IDLE; read -> RDATA.
- RDATA: owner's rvalid=1, owner's rdata=ram_rdata; other rdata=0. Next IDLE.
- Arbitration (macro enabled): both req in IDLE -> grant the one that is not last_winner. Single req always wins.
- Requester may change/drop inputs after gnt; latched copy is used. Req dropped before gnt: no transaction, no side effect.
- Requests are not accepted outside IDLE; gnt is never asserted in ACCESS/RDATA.
- ram_en/ram_we/ram_addr/ram_wdata are 0 outside ACCESS.

## Timing
- Reset (async, immediate): state IDLE; all gnt, rvalid, rdata, ram_* outputs 0; *_q cleared; last_winner=IO (CPU wins first tie).
- Read: gnt at cycle T, ram_en at T+1, rvalid+rdata at T+2; next gnt earliest T+3.
- Write: gnt at T, ram_en+ram_we at T+1; next gnt earliest T+2.
- Reset asserted in ACCESS: ram_we drops immediately, write aborted; in RDATA: rvalid drops, data lost. No transaction resumes after release.
- Reset released with req high: gnt may occur on first active cycle.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: tie broken by alternating winner (last_winner) as above.
- Not defined: fixed priority, CPU always wins a tie; last_winner register omitted; IO can starve while CPU requests back-to-back.

## Test plan
- CPU write addr 0x0010 data 0xBEEF, io_req=0 -> cpu_gnt at T, ram_en=1/ram_we=1/ram_addr=0x0010/ram_wdata=0xBEEF at T+1 only.
- CPU read 0x0010, RAM model returns 0xBEEF -> ram_en T+1 with ram_we=0, cpu_rvalid=1 and cpu_rdata=0xBEEF at T+2, io_rvalid=0, io_rdata=0.
- cpu_req and io_req held high continuously (reads), macro defined -> grant order CPU, IO, CPU, IO, one gnt per 3 cycles.
- Same stimulus, macro undefined -> every gnt to CPU; io_gnt never asserts.
- Requester changes cpu_addr from 0x0010 to 0x0020 the cycle after gnt -> ram_addr still 0x0010.
- Reset pulsed during RDATA of an IO read -> io_rvalid falls immediately, state IDLE, all outputs 0; after release, pending cpu_req gets gnt on first clock.
